// File: rtl/ctrl_pkg.sv
// Shared definitions for the pipelined control unit: opcodes, control bundle
// bit positions, forwarding select encodings and the halt FSM state type.
package ctrl_pkg;

    localparam int unsigned CTRL_W = 10;

    // Opcode map
    localparam logic [3:0] OP_ADD    = 4'h0;
    localparam logic [3:0] OP_SUB    = 4'h1;
    localparam logic [3:0] OP_XOR    = 4'h2;
    localparam logic [3:0] OP_RED    = 4'h3;
    localparam logic [3:0] OP_SLL    = 4'h4;
    localparam logic [3:0] OP_SRA    = 4'h5;
    localparam logic [3:0] OP_ROR    = 4'h6;
    localparam logic [3:0] OP_PADDSB = 4'h7;
    localparam logic [3:0] OP_LW     = 4'h8;
    localparam logic [3:0] OP_SW     = 4'h9;
    localparam logic [3:0] OP_LLB    = 4'hA;
    localparam logic [3:0] OP_LHB    = 4'hB;
    localparam logic [3:0] OP_B      = 4'hC;
    localparam logic [3:0] OP_BR     = 4'hD;
    localparam logic [3:0] OP_PCS    = 4'hE;
    localparam logic [3:0] OP_HLT    = 4'hF;

    // Control bundle bit positions
    localparam int unsigned B_REGWRITE = 9;
    localparam int unsigned B_MEMWRITE = 8;
    localparam int unsigned B_MEMTOREG = 7;
    localparam int unsigned B_MEMREAD  = 6;
    localparam int unsigned B_BRANCH   = 5;
    localparam int unsigned B_ALUSRC   = 4;
    localparam int unsigned B_LXB      = 3;
    localparam int unsigned B_PCSTORE  = 2;
    localparam int unsigned B_BRREG    = 1;
    localparam int unsigned B_HLT      = 0;

    // EX operand source selects
    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_e;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode decoder: opcode + valid -> control bundle and
// source-register usage flags. An invalid slot decodes to all zeros.
module ctrl_decode
    import ctrl_pkg::*;
(
    input  logic              valid_i,
    input  logic [3:0]        opcode_i,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic              uses_rs_o,
    output logic              uses_rt_o
);

    // Decode one opcode into its bundle and source usage
    always_comb begin
        ctrl_o    = '0;
        uses_rs_o = 1'b0;
        uses_rt_o = 1'b0;
        if (valid_i) begin
            ctrl_o[B_REGWRITE] = (opcode_i <= OP_LW) || (opcode_i == OP_LLB) ||
                                 (opcode_i == OP_LHB) || (opcode_i == OP_PCS);
            ctrl_o[B_MEMWRITE] = (opcode_i == OP_SW);
            ctrl_o[B_MEMTOREG] = (opcode_i == OP_LW);
            ctrl_o[B_MEMREAD]  = (opcode_i == OP_LW);
            ctrl_o[B_BRANCH]   = (opcode_i == OP_B) || (opcode_i == OP_BR);
            ctrl_o[B_ALUSRC]   = (opcode_i == OP_SLL) || (opcode_i == OP_SRA) ||
                                 (opcode_i == OP_ROR) || (opcode_i >= OP_LW);
            ctrl_o[B_LXB]      = (opcode_i == OP_LLB) || (opcode_i == OP_LHB);
            ctrl_o[B_PCSTORE]  = (opcode_i >= OP_B);
            ctrl_o[B_BRREG]    = (opcode_i == OP_BR);
            ctrl_o[B_HLT]      = (opcode_i == OP_HLT);
            uses_rs_o          = (opcode_i <= OP_LHB) || (opcode_i == OP_BR);
            uses_rt_o          = (opcode_i <= OP_RED) || (opcode_i == OP_PADDSB) ||
                                 (opcode_i == OP_SW);
        end
    end

endmodule

// File: rtl/ctrl_pipe_unit.sv
// Pipelined control unit: decodes in ID, carries the bundle through EX/MEM/WB,
// detects RAW hazards, drives stall / PC enable / IF flush and drains the pipe
// on HLT. Define CTRL_FWD_EN to enable EX operand forwarding, which reduces
// stalls to the load-use case only.
module ctrl_pipe_unit
    import ctrl_pkg::*;
#(
    parameter int unsigned REG_AW = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [3:0]        id_opcode,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_br_taken,
    input  logic              mem_busy,
    output logic              id_stall,
    output logic              pc_en,
    output logic              flush_if,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic [CTRL_W-1:0] mem_ctrl,
    output logic [CTRL_W-1:0] wb_ctrl,
    output logic [REG_AW-1:0] wb_rd,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic              halted
);

    state_e state_q, state_d;

    logic              id_valid_eff;
    logic [CTRL_W-1:0] id_ctrl;
    logic              uses_rs, uses_rt;
    logic              hazard;
    logic              ex_hit;

    logic              ex_valid_q, mem_valid_q;
    logic [CTRL_W-1:0] ex_ctrl_q, mem_ctrl_q, wb_ctrl_q;
    logic [REG_AW-1:0] ex_rd_q, mem_rd_q, wb_rd_q;

    // Once draining or halted, whatever sits in ID is treated as a bubble.
    assign id_valid_eff = id_valid && (state_q == RUN);

    ctrl_decode u_decode (
        .valid_i   (id_valid_eff),
        .opcode_i  (id_opcode),
        .ctrl_o    (id_ctrl),
        .uses_rs_o (uses_rs),
        .uses_rt_o (uses_rt)
    );

    assign ex_hit = (ex_rd_q != '0) &&
                    ((uses_rs && (ex_rd_q == id_rs)) || (uses_rt && (ex_rd_q == id_rt)));

`ifdef CTRL_FWD_EN
    logic [REG_AW-1:0] ex_rs_q, ex_rt_q;

    // Only a load in EX cannot be forwarded in time.
    assign hazard = ex_valid_q && ex_ctrl_q[B_MEMREAD] && ex_hit;

    // Source addresses of the EX instruction, for forwarding compares
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_rs_q <= '0;
            ex_rt_q <= '0;
        end else if (!mem_busy) begin
            ex_rs_q <= (id_valid_eff && !hazard) ? id_rs : '0;
            ex_rt_q <= (id_valid_eff && !hazard) ? id_rt : '0;
        end
    end

    // Operand source select; the younger MEM result wins over WB
    always_comb begin
        fwd_a = FWD_RF;
        fwd_b = FWD_RF;
        if (mem_valid_q && mem_ctrl_q[B_REGWRITE] && (mem_rd_q != '0) && (mem_rd_q == ex_rs_q))
            fwd_a = FWD_MEM;
        else if (wb_ctrl_q[B_REGWRITE] && (wb_rd_q != '0) && (wb_rd_q == ex_rs_q))
            fwd_a = FWD_WB;
        if (mem_valid_q && mem_ctrl_q[B_REGWRITE] && (mem_rd_q != '0) && (mem_rd_q == ex_rt_q))
            fwd_b = FWD_MEM;
        else if (wb_ctrl_q[B_REGWRITE] && (wb_rd_q != '0) && (wb_rd_q == ex_rt_q))
            fwd_b = FWD_WB;
    end
`else
    logic mem_hit;

    assign mem_hit = (mem_rd_q != '0) &&
                     ((uses_rs && (mem_rd_q == id_rs)) || (uses_rt && (mem_rd_q == id_rt)));
    // WB needs no stall: the regfile writes before it is read.
    assign hazard  = (ex_valid_q && ex_ctrl_q[B_REGWRITE] && ex_hit) ||
                     (mem_valid_q && mem_ctrl_q[B_REGWRITE] && mem_hit);
    assign fwd_a   = FWD_RF;
    assign fwd_b   = FWD_RF;
`endif

    // Halt FSM next state and pipeline control outputs; mem_busy overrides all
    always_comb begin
        state_d  = state_q;
        pc_en    = 1'b0;
        flush_if = 1'b0;
        id_stall = mem_busy || hazard;
        if (!mem_busy) begin
            unique case (state_q)
                RUN: begin
                    pc_en    = !hazard;
                    flush_if = id_ctrl[B_BRANCH] && id_br_taken && !hazard;
                    if (id_ctrl[B_HLT] && !hazard) state_d = DRAIN;
                end
                DRAIN: begin
                    flush_if = 1'b1;
                    // HLT enters WB on this edge
                    if (mem_valid_q && mem_ctrl_q[B_HLT]) state_d = HALTED;
                end
                HALTED: flush_if = 1'b1;
                default: state_d = RUN;
            endcase
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) state_q <= RUN;
        else     state_q <= state_d;
    end

    // Stage registers: freeze on mem_busy, bubble into EX on a stall
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid_q  <= 1'b0;
            ex_ctrl_q   <= '0;
            ex_rd_q     <= '0;
            mem_valid_q <= 1'b0;
            mem_ctrl_q  <= '0;
            mem_rd_q    <= '0;
            wb_ctrl_q   <= '0;
            wb_rd_q     <= '0;
        end else if (!mem_busy) begin
            ex_valid_q  <= id_valid_eff && !hazard;
            ex_ctrl_q   <= hazard ? '0 : id_ctrl;
            ex_rd_q     <= (id_valid_eff && !hazard) ? id_rd : '0;
            mem_valid_q <= ex_valid_q;
            mem_ctrl_q  <= ex_ctrl_q;
            mem_rd_q    <= ex_rd_q;
            wb_ctrl_q   <= mem_ctrl_q;
            wb_rd_q     <= mem_rd_q;
        end
    end

    assign ex_ctrl  = ex_ctrl_q;
    assign mem_ctrl = mem_ctrl_q;
    assign wb_ctrl  = wb_ctrl_q;
    assign wb_rd    = wb_rd_q;
    assign halted   = (state_q == HALTED);

endmodule

// File: tb/tb_ctrl_pipe_unit.sv
// Directed self-checking bench for ctrl_pipe_unit. Expectations adapt to the
// CTRL_FWD_EN build option.
module tb_ctrl_pipe_unit;

`ifdef CTRL_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    // Hand-decoded bundles
    localparam logic [9:0] C_ADD = 10'h200;
    localparam logic [9:0] C_LW  = 10'h2D0;
    localparam logic [9:0] C_B   = 10'h034;
    localparam logic [9:0] C_HLT = 10'h015;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid;
    logic [3:0] id_opcode;
    logic [3:0] id_rs, id_rt, id_rd;
    logic       id_br_taken;
    logic       mem_busy;
    logic       id_stall, pc_en, flush_if, halted;
    logic [9:0] ex_ctrl, mem_ctrl, wb_ctrl;
    logic [3:0] wb_rd;
    logic [1:0] fwd_a, fwd_b;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ctrl_pipe_unit #(.REG_AW(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .id_valid    (id_valid),
        .id_opcode   (id_opcode),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_rd       (id_rd),
        .id_br_taken (id_br_taken),
        .mem_busy    (mem_busy),
        .id_stall    (id_stall),
        .pc_en       (pc_en),
        .flush_if    (flush_if),
        .ex_ctrl     (ex_ctrl),
        .mem_ctrl    (mem_ctrl),
        .wb_ctrl     (wb_ctrl),
        .wb_rd       (wb_rd),
        .fwd_a       (fwd_a),
        .fwd_b       (fwd_b),
        .halted      (halted)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_id(input logic v, input logic [3:0] op, input logic [3:0] rs,
                            input logic [3:0] rt, input logic [3:0] rd, input logic br);
        id_valid    = v;
        id_opcode   = op;
        id_rs       = rs;
        id_rt       = rt;
        id_rd       = rd;
        id_br_taken = br;
        #1;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        mem_busy = 1'b0;
        drive_id(0, 4'h0, 4'h0, 4'h0, 4'h0, 0);
        tick();
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({ex_ctrl, mem_ctrl, wb_ctrl} !== 30'h0) begin
            errors++;
            $display("FAIL reset_bundles: got %h/%h/%h want 0", ex_ctrl, mem_ctrl, wb_ctrl);
        end
        checks++;
        if ({wb_rd, fwd_a, fwd_b, halted} !== 9'h0) begin
            errors++;
            $display("FAIL reset_misc: wb_rd=%h fwd=%b/%b halted=%b want 0", wb_rd, fwd_a, fwd_b,
                     halted);
        end
        checks++;
        if ({id_stall, pc_en, flush_if} !== 3'b010) begin
            errors++;
            $display("FAIL reset_ctrl: stall/pc_en/flush=%b want 010", {id_stall, pc_en, flush_if});
        end
    endtask

    task automatic test_add();
        do_reset();
        drive_id(1, 4'h0, 4'd2, 4'd3, 4'd1, 0);
        tick();
        drive_id(0, 4'h0, 4'h0, 4'h0, 4'h0, 0);
        checks++;
        if (ex_ctrl !== C_ADD || fwd_a !== 2'b00 || fwd_b !== 2'b00) begin
            errors++;
            $display("FAIL add_ex: ex_ctrl=%h fwd=%b/%b want %h 00/00", ex_ctrl, fwd_a, fwd_b, C_ADD);
        end
        tick();
        checks++;
        if (mem_ctrl !== C_ADD || ex_ctrl !== 10'h0) begin
            errors++;
            $display("FAIL add_mem: mem_ctrl=%h ex_ctrl=%h want %h 000", mem_ctrl, ex_ctrl, C_ADD);
        end
        tick();
        checks++;
        if (wb_ctrl !== C_ADD || wb_rd !== 4'd1) begin
            errors++;
            $display("FAIL add_wb: wb_ctrl=%h wb_rd=%0d want %h 1", wb_ctrl, wb_rd, C_ADD);
        end
    endtask

    // LW r4 then ADD r5,r4,r6; optionally freeze with mem_busy during the stall
    task automatic test_load_use(input bit with_busy);
        int n;
        do_reset();
        drive_id(1, 4'h8, 4'd2, 4'd0, 4'd4, 0);
        tick();
        drive_id(1, 4'h0, 4'd4, 4'd6, 4'd5, 0);
        checks++;
        if (id_stall !== 1'b1 || pc_en !== 1'b0) begin
            errors++;
            $display("FAIL lu_first_stall: stall=%b pc_en=%b want 1 0", id_stall, pc_en);
        end
        if (with_busy) begin
            mem_busy = 1'b1;
            #1;
            for (int i = 0; i < 3; i++) begin
                checks++;
                if ({id_stall, pc_en, flush_if} !== 3'b100) begin
                    errors++;
                    $display("FAIL busy_ctrl[%0d]: stall/pc_en/flush=%b want 100", i,
                             {id_stall, pc_en, flush_if});
                end
                tick();
                checks++;
                if (ex_ctrl !== C_LW || mem_ctrl !== 10'h0 || wb_ctrl !== 10'h0) begin
                    errors++;
                    $display("FAIL busy_frozen[%0d]: ex/mem/wb=%h/%h/%h want %h/000/000", i,
                             ex_ctrl, mem_ctrl, wb_ctrl, C_LW);
                end
            end
            mem_busy = 1'b0;
            #1;
        end
        n = 0;
        while (id_stall && n < 6) begin
            tick();
            n++;
        end
        checks++;
        if (n !== (FWD ? 1 : 2)) begin
            errors++;
            $display("FAIL lu_stall_cycles: got %0d want %0d", n, FWD ? 1 : 2);
        end
        checks++;
        if (ex_ctrl !== 10'h0 || pc_en !== 1'b1) begin
            errors++;
            $display("FAIL lu_bubble: ex_ctrl=%h pc_en=%b want 000 1", ex_ctrl, pc_en);
        end
        tick();
        drive_id(0, 4'h0, 4'h0, 4'h0, 4'h0, 0);
        checks++;
        if (ex_ctrl !== C_ADD || fwd_a !== (FWD ? 2'b10 : 2'b00)) begin
            errors++;
            $display("FAIL lu_fwd_a: ex_ctrl=%h fwd_a=%b want %h %b", ex_ctrl, fwd_a, C_ADD,
                     FWD ? 2'b10 : 2'b00);
        end
    endtask

    // SUB rd then XOR r2,r7,rd; rd = 0 must never hazard or forward
    task automatic test_forward(input logic [3:0] rd);
        int  n;
        bit  exp_stall;
        exp_stall = (rd != 4'd0) && !FWD;
        do_reset();
        drive_id(1, 4'h1, 4'd2, 4'd3, rd, 0);
        tick();
        drive_id(1, 4'h2, 4'd7, rd, 4'd2, 0);
        checks++;
        if (id_stall !== exp_stall) begin
            errors++;
            $display("FAIL fwd_stall_rd%0d: got %b want %b", rd, id_stall, exp_stall);
        end
        n = 0;
        while (id_stall && n < 6) begin
            tick();
            n++;
        end
        tick();
        drive_id(0, 4'h0, 4'h0, 4'h0, 4'h0, 0);
        checks++;
        if (ex_ctrl !== C_ADD || fwd_a !== 2'b00 ||
            fwd_b !== ((FWD && rd != 4'd0) ? 2'b01 : 2'b00)) begin
            errors++;
            $display("FAIL fwd_sel_rd%0d: ex=%h fwd_a=%b fwd_b=%b want %h 00 %b", rd, ex_ctrl,
                     fwd_a, fwd_b, C_ADD, (FWD && rd != 4'd0) ? 2'b01 : 2'b00);
        end
    endtask

    task automatic test_branch();
        do_reset();
        drive_id(1, 4'hC, 4'd0, 4'd0, 4'd0, 1);
        checks++;
        if (flush_if !== 1'b1 || pc_en !== 1'b1) begin
            errors++;
            $display("FAIL br_taken: flush=%b pc_en=%b want 1 1", flush_if, pc_en);
        end
        tick();
        drive_id(0, 4'h0, 4'h0, 4'h0, 4'h0, 0);
        checks++;
        if (flush_if !== 1'b0 || ex_ctrl !== C_B) begin
            errors++;
            $display("FAIL br_after: flush=%b ex=%h want 0 %h", flush_if, ex_ctrl, C_B);
        end
        drive_id(1, 4'hC, 4'd0, 4'd0, 4'd0, 0);
        checks++;
        if (flush_if !== 1'b0 || pc_en !== 1'b1) begin
            errors++;
            $display("FAIL br_not_taken: flush=%b pc_en=%b want 0 1", flush_if, pc_en);
        end
    endtask

    task automatic test_halt();
        do_reset();
        drive_id(1, 4'hF, 4'd0, 4'd0, 4'd0, 0);
        checks++;
        if (pc_en !== 1'b1 || flush_if !== 1'b0) begin
            errors++;
            $display("FAIL hlt_id: pc_en=%b flush=%b want 1 0", pc_en, flush_if);
        end
        tick();
        drive_id(1, 4'h0, 4'd2, 4'd3, 4'd1, 0);
        checks++;
        if (pc_en !== 1'b0 || flush_if !== 1'b1 || ex_ctrl !== C_HLT || halted !== 1'b0) begin
            errors++;
            $display("FAIL hlt_drain: pc_en=%b flush=%b ex=%h halted=%b want 0 1 %h 0", pc_en,
                     flush_if, ex_ctrl, halted, C_HLT);
        end
        tick();
        checks++;
        if (mem_ctrl !== C_HLT || ex_ctrl !== 10'h0 || halted !== 1'b0) begin
            errors++;
            $display("FAIL hlt_mem: mem=%h ex=%h halted=%b want %h 000 0", mem_ctrl, ex_ctrl,
                     halted, C_HLT);
        end
        tick();
        checks++;
        if (wb_ctrl !== C_HLT || halted !== 1'b1 || pc_en !== 1'b0) begin
            errors++;
            $display("FAIL hlt_wb: wb=%h halted=%b pc_en=%b want %h 1 0", wb_ctrl, halted, pc_en,
                     C_HLT);
        end
        tick();
        tick();
        checks++;
        if (halted !== 1'b1 || pc_en !== 1'b0) begin
            errors++;
            $display("FAIL hlt_sticky: halted=%b pc_en=%b want 1 0", halted, pc_en);
        end
        do_reset();
        checks++;
        if (halted !== 1'b0 || pc_en !== 1'b1) begin
            errors++;
            $display("FAIL hlt_reset: halted=%b pc_en=%b want 0 1", halted, pc_en);
        end
    endtask

    initial begin
        rst      = 1'b1;
        mem_busy = 1'b0;
        test_reset();
        test_add();
        test_load_use(1'b0);
        test_load_use(1'b1);
        test_forward(4'd1);
        test_forward(4'd0);
        test_branch();
        test_halt();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

endmodule
